// File: rtl/audio_pwm_generator.sv
// Purpose : single-bit audio DAC driver; counter PWM by default, first-order delta-sigma
//           when AUDIO_PWM_SIGMA_DELTA_EN is defined.
// Latency : pwm_out is registered, one clock after the counter/accumulator state it reflects.
// Backpressure: none; ena=0 freezes all state and forces pwm_out low.
//
// Ports:
//   clk     - system clock, all state updates on its rising edge
//   rst     - synchronous active-high reset, takes priority over ena
//   ena     - clock enable; state advances only on enabled edges
//   audio   - unsigned offset-binary sample (0 = most negative, 2^(AUDIO_BITS-1) = midscale)
//   pwm_out - registered single-bit modulated output
//
// Build option: define AUDIO_PWM_SIGMA_DELTA_EN to select the delta-sigma modulator.
module audio_pwm_generator #(
    parameter int AUDIO_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [AUDIO_BITS-1:0] audio,
    output logic                  pwm_out
);

    localparam logic [AUDIO_BITS-1:0] ONE = {{(AUDIO_BITS-1){1'b0}}, 1'b1};

    logic r_pwm;

`ifdef AUDIO_PWM_SIGMA_DELTA_EN

    // First-order delta-sigma: the carry out of the accumulator is the output bit.
    // Over any 2^AUDIO_BITS enabled cycles with constant audio A, exactly A carries occur.
    logic [AUDIO_BITS-1:0] r_acc;
    logic [AUDIO_BITS:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, audio};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_pwm <= 1'b0;
        end else if (ena) begin
            r_acc <= w_sum[AUDIO_BITS-1:0];
            r_pwm <= w_sum[AUDIO_BITS];
        end else begin
            r_pwm <= 1'b0;
        end
    end

`else

    // Counter PWM: duty is captured only on the last count of a period so a sample
    // change mid-period never distorts the period in progress.
    localparam logic [AUDIO_BITS-1:0] CNT_LAST = '1;

    logic [AUDIO_BITS-1:0] r_cnt;
    logic [AUDIO_BITS-1:0] r_duty;
    logic                  w_period_end;
    logic                  w_pwm_next;

    assign w_period_end = (r_cnt == CNT_LAST);
    // Compare uses pre-edge cnt and duty, so high cycles start at the first cycle of a window.
    assign w_pwm_next   = (r_cnt < r_duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else if (ena) begin
            r_cnt <= r_cnt + ONE;
            if (w_period_end) begin
                r_duty <= audio;
            end
            r_pwm <= w_pwm_next;
        end else begin
            // Gated edges hold the period position; output is muted, not stretched.
            r_pwm <= 1'b0;
        end
    end

`endif

    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_audio_pwm_generator.sv
// Purpose : directed self-checking bench for audio_pwm_generator (counter PWM build).
// Latency : windows are measured on pwm_out sampled 1 time unit after each rising edge.
// Backpressure: not applicable; ena gating exercised directly.
module tb_audio_pwm_generator;

    localparam int PERIOD = 4096;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [11:0] audio;
    logic        pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    audio_pwm_generator #(.AUDIO_BITS(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .audio   (audio),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; return 1 time unit later so outputs are settled and inputs
    // can be changed well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one aligned window of PERIOD enabled edges.
    //   chg_at/chg_val : before enabled edge chg_at, audio <= chg_val (chg_at<0 disables)
    //   gate_at/gate_len: before enabled edge gate_at, hold ena=0 for gate_len edges
    // Returns the high count over enabled samples, the length of the leading high run,
    // and the high count seen during the gated edges.
    task automatic run_window(input int chg_at, input logic [11:0] chg_val,
                              input int gate_at, input int gate_len,
                              output int highs, output int lead, output int gated_highs);
        highs       = 0;
        lead        = 0;
        gated_highs = 0;
        for (int j = 0; j < PERIOD; j++) begin
            if (j == chg_at) audio = chg_val;
            if (j == gate_at) begin
                ena = 1'b0;
                for (int g = 0; g < gate_len; g++) begin
                    tick();
                    if (pwm_out !== 1'b0) gated_highs++;
                end
                ena = 1'b1;
            end
            tick();
            if (pwm_out === 1'b1) begin
                highs++;
                if (lead == j) lead++;
            end
        end
    endtask

    int h, l, gh;

    initial begin
        rst   = 1'b1;
        ena   = 1'b1;
        audio = 12'd3000;

        // Reset for two edges with a nonzero sample present.
        tick();
        tick();
        check_eq("reset_pwm", int'(pwm_out), 0);

        rst   = 1'b0;
        audio = 12'd0;

        // First period after reset uses duty 0; second uses audio=0.
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("w0_reset_duty_highs", h, 0);
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("w1_audio0_highs", h, 0);

        // Midscale: loading period still shows duty 0, next period 2048 contiguous highs.
        audio = 12'd2048;
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("w2_load_highs", h, 0);
        audio = 12'd4095;
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("mid_highs", h, 2048);
        check_eq("mid_lead", l, 2048);

        // Full scale: 4095 highs then one low.
        audio = 12'd1;
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("full_highs", h, 4095);
        check_eq("full_lead", l, 4095);

        // Smallest nonzero: one high in the first cycle of the window.
        audio = 12'd1000;
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("one_highs", h, 1);
        check_eq("one_lead", l, 1);

        // Mid-period change 1000 -> 3000 at cnt=500 does not touch this period.
        run_window(500, 12'd3000, -1, 0, h, l, gh);
        check_eq("chg_cur_highs", h, 1000);
        check_eq("chg_cur_lead", l, 1000);
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("chg_next_highs", h, 3000);
        check_eq("chg_next_lead", l, 3000);

        // Enable gating for 100 edges at cnt=1500; sample switched to 200 mid-period
        // so the next window also proves the counter resumed without a restart.
        run_window(2000, 12'd200, 1500, 100, h, l, gh);
        check_eq("gate_pwm_low", gh, 0);
        check_eq("gate_highs", h, 3000);
        check_eq("gate_lead", l, 3000);
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("post_gate_highs", h, 200);
        check_eq("post_gate_lead", l, 200);

        // Reset mid-period (duty 200 active): aborts the period, next period duty 0.
        for (int k = 0; k < 100; k++) tick();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        tick();
        check_eq("midrst_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        ena = 1'b1;
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("midrst_w0_highs", h, 0);
        run_window(-1, 12'd0, -1, 0, h, l, gh);
        check_eq("midrst_w1_highs", h, 200);
        check_eq("midrst_w1_lead", l, 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
